// File: rtl/heard_buffer_if.sv
// heard_buffer_if: heard (enqueue) and out_put (dequeue) handshake bundle for heard_buffer
interface heard_buffer_if;
  logic        heard__ENA;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        out_put__ENA;
  logic [31:0] out_put_v;
  logic        out_put__RDY;
  modport slave (
    input  heard__ENA, heard_v, out_put__RDY,
    output heard__RDY, out_put__ENA, out_put_v
  );
  modport master (
    output heard__ENA, heard_v, out_put__RDY,
    input  heard__RDY, out_put__ENA, out_put_v
  );
endinterface

// File: rtl/heard_buffer.sv
// heard_buffer: DEPTH-entry FIFO, no bypass; define HEARD_BUFFER_STATS_EN to add accepted_total/full_cycles counters
module heard_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  heard_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef HEARD_BUFFER_STATS_EN
  ,
  output logic [31:0]            accepted_total,
  output logic [31:0]            full_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  state_e        state;
  logic          enq, deq;
  always_comb state = (occ_q == '0) ? EMPTY : (occ_q == FULL_OCC) ? FULL : PARTIAL;
  assign bus.heard__RDY   = state != FULL;
  assign bus.out_put__ENA = state != EMPTY;
  assign bus.out_put_v    = mem_q[rd_ptr_q];
  assign enq              = bus.heard__ENA & bus.heard__RDY;
  assign deq              = bus.out_put__ENA & bus.out_put__RDY;
  assign occupancy        = occ_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    occ_d    = (enq & ~deq) ? occ_q + 1'b1 : (deq & ~enq) ? occ_q - 1'b1 : occ_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q] <= bus.heard_v;
  end
`ifdef HEARD_BUFFER_STATS_EN
  logic [31:0] accepted_q, full_cycles_q;
  assign accepted_total = accepted_q;
  assign full_cycles    = full_cycles_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      accepted_q    <= '0;
      full_cycles_q <= '0;
    end else begin
      accepted_q    <= accepted_q + 32'(enq);
      full_cycles_q <= full_cycles_q + 32'(state == FULL);
    end
  end
`endif
endmodule

// File: tb/tb_heard_buffer.sv
// tb_heard_buffer: directed and random checks of heard_buffer against a queue model
module tb_heard_buffer;
  localparam int DEPTH = 4;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [2:0]  occupancy;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q [$];
  logic [31:0] m_accepted = 0;
  logic [31:0] m_full = 0;
  heard_buffer_if bus ();
`ifdef HEARD_BUFFER_STATS_EN
  logic [31:0] accepted_total, full_cycles;
`endif
  heard_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus),
    .occupancy(occupancy)
`ifdef HEARD_BUFFER_STATS_EN
    ,
    .accepted_total(accepted_total),
    .full_cycles(full_cycles)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag);
    vectors++;
    assert (bus.heard__RDY === (q.size() < DEPTH)) else begin
      miscompares++;
      $error("FAIL %s rdy: got %b want %b", tag, bus.heard__RDY, q.size() < DEPTH);
    end
    vectors++;
    assert (bus.out_put__ENA === (q.size() != 0)) else begin
      miscompares++;
      $error("FAIL %s ena: got %b want %b", tag, bus.out_put__ENA, q.size() != 0);
    end
    vectors++;
    assert (occupancy === 3'(q.size())) else begin
      miscompares++;
      $error("FAIL %s occ: got %0d want %0d", tag, occupancy, q.size());
    end
    if (q.size() != 0) begin
      vectors++;
      assert (bus.out_put_v === q[0]) else begin
        miscompares++;
        $error("FAIL %s data: got %h want %h", tag, bus.out_put_v, q[0]);
      end
    end
`ifdef HEARD_BUFFER_STATS_EN
    vectors++;
    assert (accepted_total === m_accepted) else begin
      miscompares++;
      $error("FAIL %s accepted: got %0d want %0d", tag, accepted_total, m_accepted);
    end
    vectors++;
    assert (full_cycles === m_full) else begin
      miscompares++;
      $error("FAIL %s full_cycles: got %0d want %0d", tag, full_cycles, m_full);
    end
`endif
  endtask
  task automatic cycle(input logic ena, input logic [31:0] d, input logic rdy, input string tag);
    logic e, x;
    bus.heard__ENA   = ena;
    bus.heard_v      = d;
    bus.out_put__RDY = rdy;
    check(tag);
    e = ena && (q.size() < DEPTH);
    x = rdy && (q.size() != 0);
    if (q.size() == DEPTH) m_full++;
    @(posedge CLK);
    if (x) void'(q.pop_front());
    if (e) begin
      q.push_back(d);
      m_accepted++;
    end
    #1;
  endtask
  task automatic model_reset();
    q.delete();
    m_accepted = 0;
    m_full = 0;
  endtask
  initial begin
    bus.heard__ENA = 0;
    bus.heard_v = 0;
    bus.out_put__RDY = 0;
    #2;
    check("in_reset");
    #10 nRST = 1'b1;
    @(posedge CLK);
    #1;
    check("idle");
    cycle(1, 32'h11, 0, "enq11");
    check("first_out");
    cycle(0, 0, 1, "deq11");
    for (int i = 0; i < 4; i++) cycle(1, 32'hA0 + i, 0, "fill");
    check("full");
    cycle(0, 0, 1, "deq_a0");
    check("after_deq");
    for (int i = 1; i <= 20; i++) cycle(1, i, 1, "stream");
    cycle(0, 0, 1, "drain");
    for (int i = 0; i < 4; i++) cycle(1, 32'hB0 + i, 0, "refill");
    cycle(1, 32'hC0, 0, "full_hold");
    cycle(1, 32'hC0, 1, "full_enq_deq");
    cycle(1, 32'hC0, 0, "held_accept");
    check("full_again");
    cycle(0, 0, 1, "to_three");
    check("occ3");
    nRST = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    #2 nRST = 1'b1;
    cycle(1, 32'h55, 0, "post_rst_enq");
    check("post_rst_out");
    cycle(0, 0, 1, "post_rst_deq");
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom, (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0), "random");
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, "final_drain");
    check("end");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
